jtkiwi_shram: RTL and testbench

Shared-RAM responder for the Kiwi main/sub CPU pair. It owns the 8 kB main/sub shared RAM and serves two initiators: the main CPU and the sub CPU, whose request arrives over the shr_* bus. It arbitrates single-port access and stretches each CPU's bus cycle with a wait signal. It reports main-side ownership on mshramen so the sub CPU side can gate its own decoding.

---
 rtl/jtkiwi_shram_pkg.sv | 21 ++
 rtl/jtframe_ram.sv | 27 ++
 rtl/jtkiwi_shram.sv | 110 +++++++++++
 tb/tb_jtkiwi_shram.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/jtkiwi_shram_pkg.sv
// Shared definitions for the Kiwi main/sub shared-RAM arbiter:
// FSM states, owner encoding and the grant-selection helper.
package jtkiwi_shram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic OWN_MAIN = 1'b0;
    localparam logic OWN_SUB  = 1'b1;

    // Main wins when alone; on a tie the requester that lost last time wins.
    function automatic logic pick_owner(input logic main_pend, input logic sub_pend,
                                        input logic last_winner);
        if (main_pend && sub_pend) return ~last_winner;
        return main_pend ? OWN_MAIN : OWN_SUB;
    endfunction

endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM: write on the clock edge, registered read.
module jtframe_ram #(
    parameter int AW = 13,
    parameter int DW = 8,
    parameter     SIMHEXFILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          we,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:2**AW-1];

    // Preloading is left to simulation-only wrappers; synthesis sees plain RAM.
    generate
        if (SIMHEXFILE != "") begin : g_simhex
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= data;
        q <= mem[addr];
    end

endmodule

// File: rtl/jtkiwi_shram.sv
// Shared 8 kB RAM between the Kiwi main and sub CPUs: one access per cs
// assertion, alternating on ties, with wait stretching each CPU cycle.
module jtkiwi_shram
    import jtkiwi_shram_pkg::*;
#(
    parameter int AW = 13,
    parameter     SIMHEXFILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_din,
    output logic [7:0]    main_dout,
    output logic          main_wait,
    input  logic          shr_cs,
    input  logic          sub_rnw,
    input  logic [AW-1:0] shr_addr,
    input  logic [7:0]    shr_dout,
    output logic [7:0]    shr_din,
    output logic          sub_wait,
    output logic          mshramen
);

    state_t        state;
    logic          owner, last_winner;
    logic          main_done, sub_done;
    logic [AW-1:0] lat_addr;
    logic          lat_rnw;
    logic [7:0]    lat_wdata;
    logic [7:0]    ram_q;

    logic main_pend, sub_pend;
    logic grant_en, grant_who;

    assign main_pend = main_cs & ~main_done;
    assign sub_pend  = shr_cs  & ~sub_done;
    assign main_wait = main_pend;
    assign sub_wait  = sub_pend;

    // A new grant starts from IDLE, or chains straight from DATA to the other side.
    always_comb begin
        grant_en  = 1'b0;
        grant_who = OWN_MAIN;
        if (state == IDLE) begin
            grant_en  = main_pend | sub_pend;
            grant_who = pick_owner(main_pend, sub_pend, last_winner);
        end else if (state == DATA) begin
            grant_who = ~owner;
            grant_en  = (owner == OWN_MAIN) ? sub_pend : main_pend;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_MAIN;
            last_winner <= OWN_SUB;
            main_done   <= 1'b0;
            sub_done    <= 1'b0;
            lat_addr    <= '0;
            lat_rnw     <= 1'b1;
            lat_wdata   <= 8'd0;
            main_dout   <= 8'd0;
            shr_din     <= 8'd0;
            mshramen    <= 1'b0;
        end else begin
            main_done <= main_cs & (main_done | (state == DATA && owner == OWN_MAIN));
            sub_done  <= shr_cs  & (sub_done  | (state == DATA && owner == OWN_SUB));

            if (state == DATA && lat_rnw) begin
                if (owner == OWN_MAIN) main_dout <= ram_q;
                else                   shr_din   <= ram_q;
            end

            if (grant_en) begin
                state       <= ACC;
                owner       <= grant_who;
                last_winner <= grant_who;
                mshramen    <= (grant_who == OWN_MAIN);
                lat_addr    <= (grant_who == OWN_MAIN) ? main_addr : shr_addr;
                lat_rnw     <= (grant_who == OWN_MAIN) ? main_rnw  : sub_rnw;
                lat_wdata   <= (grant_who == OWN_MAIN) ? main_din  : shr_dout;
            end else begin
                case (state)
                    ACC:     state <= DATA;
                    DATA: begin
                        state    <= IDLE;
                        mshramen <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    jtframe_ram #(
        .AW         (AW),
        .DW         (8),
        .SIMHEXFILE (SIMHEXFILE)
    ) u_ram (
        .clk  (clk),
        .addr (lat_addr),
        .data (lat_wdata),
        .we   (state == ACC && !lat_rnw),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_jtkiwi_shram.sv
// Self-checking bench for jtkiwi_shram: vector table plus hand-written
// tie, hold, alternation and reset sequences with a read-data scoreboard.
module tb_jtkiwi_shram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        main_cs = 1'b0, main_rnw = 1'b1;
    logic [12:0] main_addr = '0;
    logic [7:0]  main_din = '0;
    logic [7:0]  main_dout;
    logic        main_wait;
    logic        shr_cs = 1'b0, sub_rnw = 1'b1;
    logic [12:0] shr_addr = '0;
    logic [7:0]  shr_dout = '0;
    logic [7:0]  shr_din;
    logic        sub_wait;
    logic        mshramen;

    always #5 clk = ~clk;

    jtkiwi_shram #(.AW(13), .SIMHEXFILE("")) dut (
        .clk       (clk),
        .rst       (rst),
        .main_cs   (main_cs),
        .main_rnw  (main_rnw),
        .main_addr (main_addr),
        .main_din  (main_din),
        .main_dout (main_dout),
        .main_wait (main_wait),
        .shr_cs    (shr_cs),
        .sub_rnw   (sub_rnw),
        .shr_addr  (shr_addr),
        .shr_dout  (shr_dout),
        .shr_din   (shr_din),
        .sub_wait  (sub_wait),
        .mshramen  (mshramen)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] main_q[$];
    logic [7:0] sub_q[$];
    bit         order_q[$];
    logic [7:0] last_main_rd = 8'd0;
    logic [7:0] last_sub_rd  = 8'd0;

    typedef struct {
        bit          who;     // 0 = main, 1 = sub
        bit          rnw;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        int          exp_lat;
        int          exp_mshr; // edges with mshramen high while waiting
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One access by one initiator; exp_lat/exp_mshr < 0 skip those checks.
    task automatic xfer(input bit who, input bit rnw, input logic [12:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd,
                        input int exp_lat, input int exp_mshr, input bit drop);
        int lat;
        int ms;
        bit w;
        logic [7:0] exp_v;
        lat = 0;
        ms  = 0;
        @(negedge clk);
        if (!who) begin
            main_cs = 1'b1; main_rnw = rnw; main_addr = a; main_din = d;
            if (rnw) main_q.push_back(exp_rd);
        end else begin
            shr_cs = 1'b1; sub_rnw = rnw; shr_addr = a; shr_dout = d;
            if (rnw) sub_q.push_back(exp_rd);
        end
        do begin
            @(posedge clk);
            #1;
            lat++;
            ms += int'(mshramen);
            w = who ? sub_wait : main_wait;
        end while (w && lat < 20);
        order_q.push_back(who);
        if (exp_lat > 0) chk(who ? "sub_latency" : "main_latency", lat, exp_lat);
        else             chk("latency_bound", lat <= 5, 1);
        if (exp_mshr >= 0) chk("mshramen_edges", ms, exp_mshr);
        if (rnw) begin
            if (!who) begin
                exp_v = main_q.pop_front();
                chk("main_dout", main_dout, exp_v);
                last_main_rd = exp_v;
            end else begin
                exp_v = sub_q.pop_front();
                chk("shr_din", shr_din, exp_v);
                last_sub_rd = exp_v;
            end
        end
        if (who) chk("main_dout_kept", main_dout, last_main_rd);
        else     chk("shr_din_kept", shr_din, last_sub_rd);
        $display("[TB] %s %s addr=%h data=%h latency=%0d",
                 who ? "sub " : "main", rnw ? "rd" : "wr", a,
                 rnw ? (who ? shr_din : main_dout) : d, lat);
        if (drop) begin
            if (!who) main_cs = 1'b0; else shr_cs = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin
        int lat;
        logic [7:0] exp_v;

        vecs[0] = '{0, 0, 13'h0010, 8'hA5, 8'h00, 3, 2};
        vecs[1] = '{0, 1, 13'h0010, 8'h00, 8'hA5, 3, 2};
        vecs[2] = '{1, 0, 13'h1FFF, 8'h3C, 8'h00, 3, 0};
        vecs[3] = '{1, 1, 13'h1FFF, 8'h00, 8'h3C, 3, 0};
        vecs[4] = '{1, 0, 13'h0000, 8'h5A, 8'h00, 3, 0};
        vecs[5] = '{0, 1, 13'h0000, 8'h00, 8'h5A, 3, 2};
        vecs[6] = '{0, 0, 13'h1FFF, 8'hC3, 8'h00, 3, 2};
        vecs[7] = '{1, 1, 13'h1FFF, 8'h00, 8'hC3, 3, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_main_dout", main_dout, 8'h00);
        chk("rst_shr_din", shr_din, 8'h00);
        chk("rst_mshramen", mshramen, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_main_wait", main_wait, 1'b0);
        chk("idle_sub_wait", sub_wait, 1'b0);

        for (int i = 0; i < 8; i++)
            xfer(vecs[i].who, vecs[i].rnw, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rd, vecs[i].exp_lat, vecs[i].exp_mshr, 1'b1);

        // Simultaneous requests: main wins first, sub chained sees the new data.
        fork
            xfer(1'b0, 1'b0, 13'h0100, 8'h11, 8'h00, 3, 2, 1'b1);
            xfer(1'b1, 1'b1, 13'h0100, 8'h00, 8'h11, 5, -1, 1'b1);
        join

        // Holding shr_cs after completion must not trigger another access.
        xfer(1'b1, 1'b0, 13'h0200, 8'h77, 8'h00, 3, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("hold_sub_wait", sub_wait, 1'b0);
            chk("hold_mshramen", mshramen, 1'b0);
        end
        shr_cs = 1'b0;
        @(posedge clk);
        xfer(1'b1, 1'b1, 13'h0200, 8'h00, 8'h77, 3, 0, 1'b1);

        // Continuous re-requests from both sides must alternate.
        order_q.delete();
        fork
            for (int i = 0; i < 4; i++)
                xfer(1'b0, 1'b0, 13'h0300 + 13'(i), 8'h40 + 8'(i), 8'h00, -1, -1, 1'b1);
            for (int i = 0; i < 4; i++)
                xfer(1'b1, 1'b0, 13'h0310 + 13'(i), 8'h80 + 8'(i), 8'h00, -1, -1, 1'b1);
        join
        chk("alt_count", order_q.size(), 8);
        if (order_q.size() == 8) begin
            chk("alt_first_main", order_q[0], 1'b0);
            for (int i = 1; i < 8; i++)
                chk("alt_toggle", order_q[i] ^ order_q[i-1], 1'b1);
        end
        xfer(1'b0, 1'b1, 13'h0312, 8'h00, 8'h82, 3, 2, 1'b1);

        // Reset during DATA of a main read, cs held: re-served from scratch.
        @(negedge clk);
        main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h0010;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_main_dout", main_dout, 8'h00);
        chk("midrst_shr_din", shr_din, 8'h00);
        chk("midrst_mshramen", mshramen, 1'b0);
        chk("midrst_main_wait", main_wait, 1'b1);
        last_main_rd = 8'h00;
        last_sub_rd  = 8'h00;
        main_q.push_back(8'hA5);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (main_wait && lat < 20);
        chk("rst_reserve_latency", lat, 3);
        exp_v = main_q.pop_front();
        chk("rst_reserve_dout", main_dout, exp_v);
        $display("[TB] main rd addr=0010 data=%h latency=%0d (after reset)", main_dout, lat);
        main_cs = 1'b0;
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
